// File: rtl/fantasticfft_ifft8_stream.sv
// Streaming 8-point inverse FFT.
// Bins arrive in natural order over in_valid/in_ready and are stored at their
// bit-reversed address. Three in-place radix-2 DIT stages follow, one per
// cycle, each halving its results so the frame carries the 1/8 scale. The
// time samples then drain in natural order over out_valid/out_ready.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. in_ready and out_valid depend only on state, never on the partner's
// valid/ready. Data and out_last are stable while out_valid && !out_ready.
module fantasticfft_ifft8_stream #(
  parameter int INT_SIZE  = 8,
  parameter int FRAC_SIZE = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INT_SIZE+FRAC_SIZE-1:0] in_re,
  input  logic [INT_SIZE+FRAC_SIZE-1:0] in_im,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INT_SIZE+FRAC_SIZE-1:0] out_re,
  output logic [INT_SIZE+FRAC_SIZE-1:0] out_im,
  output logic                          out_last
);

  localparam int W  = INT_SIZE + FRAC_SIZE;  // sample word
  localparam int WT = W + 1;                 // twiddle sums / products
  localparam int WB = W + 2;                 // butterfly sums
  localparam int WP = WT + 10;               // twiddle multiply
  // c = 181/256 ~ 1/sqrt(2); the shift matches the 8 fractional bits of c,
  // so the product stays in the sample format.
  localparam logic signed [WP-1:0] C_Q    = WP'(181);
  localparam int                   C_FRAC = 8;

  localparam logic signed [W-1:0]  MAX_W = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  MIN_W = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [WB-1:0] MAX_B = WB'(MAX_W);
  localparam logic signed [WB-1:0] MIN_B = WB'(MIN_W);

  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [2:0]           in_cnt, out_cnt;
  logic                 in_fire, out_fire, compute_en;

  logic signed [W-1:0]  buf_re [8];
  logic signed [W-1:0]  buf_im [8];
  logic signed [W-1:0]  nxt_re [8];
  logic signed [W-1:0]  nxt_im [8];

  logic [2:0]           lo_idx [4];
  logic [2:0]           hi_idx [4];
  logic [1:0]           tw_m   [4];
  logic signed [W-1:0]  a_re [4], a_im [4], b_re [4], b_im [4];
  logic signed [WT-1:0] t_re [4], t_im [4];

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // v * c, floored
  function automatic logic signed [WT-1:0] mul_c(input logic signed [WT-1:0] v);
    logic signed [WP-1:0] p;
    p = WP'(v) * C_Q;
    return WT'(p >>> C_FRAC);
  endfunction

  // Real part of W^m * (re + j*im), W = e^(+j*2*pi/8)
  function automatic logic signed [WT-1:0] tw_real(input logic [1:0] m,
                                                   input logic signed [W-1:0] re,
                                                   input logic signed [W-1:0] im);
    logic signed [WT-1:0] r;
    case (m)
      2'd0:    r = WT'(re);
      2'd1:    r = mul_c(WT'(re) - WT'(im));
      2'd2:    r = -WT'(im);
      default: r = -mul_c(WT'(re) + WT'(im));
    endcase
    return r;
  endfunction

  // Imaginary part of W^m * (re + j*im)
  function automatic logic signed [WT-1:0] tw_imag(input logic [1:0] m,
                                                   input logic signed [W-1:0] re,
                                                   input logic signed [W-1:0] im);
    logic signed [WT-1:0] r;
    case (m)
      2'd0:    r = WT'(im);
      2'd1:    r = mul_c(WT'(re) + WT'(im));
      2'd2:    r = WT'(re);
      default: r = mul_c(WT'(re) - WT'(im));
    endcase
    return r;
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [WB-1:0] v);
    logic signed [W-1:0] r;
    if (v > MAX_B)      r = MAX_W;
    else if (v < MIN_B) r = MIN_W;
    else                r = W'(v);
    return r;
  endfunction

  // (a + t) >>> 1 and (a - t) >>> 1, saturated back to the word
  function automatic logic signed [W-1:0] bf_add(input logic signed [W-1:0] a,
                                                 input logic signed [WT-1:0] t);
    logic signed [WB-1:0] s;
    s = (WB'(a) + WB'(t)) >>> 1;
    return sat(s);
  endfunction

  function automatic logic signed [W-1:0] bf_sub(input logic signed [W-1:0] a,
                                                 input logic signed [WT-1:0] t);
    logic signed [WB-1:0] s;
    s = (WB'(a) - WB'(t)) >>> 1;
    return sat(s);
  endfunction

  // State register, counters and frame buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_LOAD;
      in_cnt  <= '0;
      out_cnt <= '0;
      for (int j = 0; j < 8; j++) begin
        buf_re[j] <= '0;
        buf_im[j] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        buf_re[bitrev3(in_cnt)] <= $signed(in_re);
        buf_im[bitrev3(in_cnt)] <= $signed(in_im);
        in_cnt <= in_cnt + 3'd1;
      end
      if (compute_en) begin
        for (int j = 0; j < 8; j++) begin
          buf_re[j] <= nxt_re[j];
          buf_im[j] <= nxt_im[j];
        end
      end
      if (out_fire) out_cnt <= out_cnt + 3'd1;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_re     = '0;
    out_im     = '0;
    compute_en = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && in_cnt == 3'd7) state_nxt = ST_S1;
      end
      ST_S1: begin
        compute_en = 1'b1;
        state_nxt  = ST_S2;
      end
      ST_S2: begin
        compute_en = 1'b1;
        state_nxt  = ST_S3;
      end
      ST_S3: begin
        compute_en = 1'b1;
        state_nxt  = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        out_re    = buf_re[out_cnt];
        out_im    = buf_im[out_cnt];
        out_last  = (out_cnt == 3'd7);
        if (out_ready && out_cnt == 3'd7) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Butterfly pairing for the current stage: span 1, 2, 4 in S1, S2, S3
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      lo_idx[p] = '0;
      hi_idx[p] = '0;
      tw_m[p]   = '0;
      case (state)
        ST_S1: begin
          lo_idx[p] = 3'(2 * p);
          hi_idx[p] = 3'(2 * p + 1);
        end
        ST_S2: begin
          lo_idx[p] = 3'((p / 2) * 4 + (p % 2));
          hi_idx[p] = 3'((p / 2) * 4 + (p % 2) + 2);
          tw_m[p]   = 2'((p % 2) * 2);
        end
        ST_S3: begin
          lo_idx[p] = 3'(p);
          hi_idx[p] = 3'(p + 4);
          tw_m[p]   = 2'(p);
        end
        default: ;
      endcase
    end
  end

  // Operand fetch and twiddle products for the four butterflies
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      a_re[p] = buf_re[lo_idx[p]];
      a_im[p] = buf_im[lo_idx[p]];
      b_re[p] = buf_re[hi_idx[p]];
      b_im[p] = buf_im[hi_idx[p]];
      t_re[p] = tw_real(tw_m[p], b_re[p], b_im[p]);
      t_im[p] = tw_imag(tw_m[p], b_re[p], b_im[p]);
    end
  end

  // Stage results written back in place
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      nxt_re[j] = buf_re[j];
      nxt_im[j] = buf_im[j];
    end
    for (int p = 0; p < 4; p++) begin
      nxt_re[lo_idx[p]] = bf_add(a_re[p], t_re[p]);
      nxt_im[lo_idx[p]] = bf_add(a_im[p], t_im[p]);
      nxt_re[hi_idx[p]] = bf_sub(a_re[p], t_re[p]);
      nxt_im[hi_idx[p]] = bf_sub(a_im[p], t_im[p]);
    end
  end

endmodule
